// File: rtl/bd_clk_sequencer_if.sv
// Control/status bundle between the BD IO clock sequencer and its environment.
interface bd_clk_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic               enable;
  logic               pll_locked;
  logic               pll_reset;
  logic               bd_io_reset;
  logic               clk_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;
  logic [7:0]         lock_loss_count;

  modport master (
    output enable, pll_locked,
    input  pll_reset, bd_io_reset, clk_ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    input  enable, pll_locked,
    output pll_reset, bd_io_reset, clk_ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/bd_clk_sequencer.sv
// BD IO PLL bring-up/recovery sequencer: PLL reset, lock wait with bounded retries,
// lock stability qualification, then release of BD IO logic reset.
module bd_clk_sequencer #(
  parameter int RST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT       = 100000,
  parameter int MAX_RETRIES        = 3
) (
  input logic               clk_i,
  input logic               reset_i,
  bd_clk_sequencer_if.slave bus
);
  localparam int MAX_RS  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_ALL = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  // state     | meaning
  // IDLE      | disabled, PLL and BD IO held in reset
  // PLL_RST   | PLL reset asserted for RST_CYCLES
  // WAIT_LOCK | PLL running, waiting for lock with timeout
  // STABLE    | lock seen, qualifying for LOCK_STABLE_CYCLES
  // RUN       | clocks ready, BD IO released
  // FAULT     | retries exhausted, sticky until disabled
  typedef enum logic [2:0] {
    S_IDLE, S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         llc_q, llc_d;
  logic               sync1_q, lock_s_q;
  logic               pll_reset_q, pll_reset_d;
  logic               bd_io_reset_q, bd_io_reset_d;
  logic               clk_ready_q, clk_ready_d;
  logic               fault_q, fault_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_q       <= '0;
      llc_q         <= '0;
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      pll_reset_q   <= 1'b1;
      bd_io_reset_q <= 1'b1;
      clk_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      llc_q         <= llc_d;
      sync1_q       <= bus.pll_locked;
      lock_s_q      <= sync1_q;
      pll_reset_q   <= pll_reset_d;
      bd_io_reset_q <= bd_io_reset_d;
      clk_ready_q   <= clk_ready_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    llc_d   = llc_q;
    // Disable overrides every other event, including a coincident lock loss in RUN.
    if (state_q != S_IDLE && !bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = S_PLL_RST;
            end else begin
              state_d = S_FAULT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
            if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the next state so they align with the state register.
  always_comb begin
    pll_reset_d   = 1'b1;
    bd_io_reset_d = 1'b1;
    clk_ready_d   = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      S_WAIT_LOCK,
      S_STABLE:    pll_reset_d = 1'b0;
      S_RUN: begin
        pll_reset_d   = 1'b0;
        bd_io_reset_d = 1'b0;
        clk_ready_d   = 1'b1;
      end
      S_FAULT:     fault_d = 1'b1;
      default:     pll_reset_d = 1'b1;
    endcase
  end

  assign bus.pll_reset       = pll_reset_q;
  assign bus.bd_io_reset     = bd_io_reset_q;
  assign bus.clk_ready       = clk_ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = llc_q;

endmodule
